// File: rtl/tile_rom_arbiter.sv
// tile_rom_arbiter: shares one 32-bit graphics-ROM SDRAM read channel among
// four fetch requesters. Port 0 has fixed priority, bounded by a starvation
// limit. Ports 1-3 are served round-robin. One read is in flight at a time,
// and a watchdog aborts a read whose SDRAM acknowledge never arrives.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req[3:0]            per-port request; a rising edge starts a read
//   addr[83:0]          packed per-port word address, port i at [21*i +: 21]
//   data[31:0]          read data, valid while the matching rdy bit is high
//   rdy[3:0]            one-hot, one-cycle completion pulse
//   err                 pulses with rdy when the read timed out
//   ovf[3:0]            pulses when a new request replaced a pending one
//   busy                high while a read is outstanding
//   sdr_addr/sdr_req    SDRAM word address and one-cycle issue pulse
//   sdr_data/sdr_rdy    SDRAM read data and data-valid pulse
module tile_rom_arbiter #(
  parameter logic [24:0] BASE_ADDR    = 25'h0000000,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64,
  localparam int unsigned NP  = 4,
  localparam int unsigned AW  = 21,
  localparam int unsigned DW  = 32,
  localparam int unsigned SAW = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NP-1:0]    req,
  input  logic [NP*AW-1:0] addr,
  output logic [DW-1:0]    data,
  output logic [NP-1:0]    rdy,
  output logic             err,
  output logic [NP-1:0]    ovf,
  output logic             busy,
  output logic [SAW-1:0]   sdr_addr,
  output logic             sdr_req,
  input  logic [DW-1:0]    sdr_data,
  input  logic             sdr_rdy
);

  localparam int unsigned TW = 8;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                state_q, state_n;
  logic [NP-1:0]         pend_q, pend_n;
  logic [NP-1:0]         req_d_q;
  logic [NP-1:0][AW-1:0] paddr_q, paddr_n;
  logic [SW-1:0]         starve_q, starve_n;
  logic [1:0]            rr_last_q, rr_last_n;
  logic [1:0]            sel_q, sel_n;
  logic [TW-1:0]         timer_q, timer_n;
  logic [DW-1:0]         data_q, data_n;
  logic [NP-1:0]         rdy_q, rdy_n;
  logic [NP-1:0]         ovf_q, ovf_n;
  logic                  err_q, err_n;
  logic                  busy_q, busy_n;
  logic [SAW-1:0]        sdr_addr_q, sdr_addr_n;
  logic                  sdr_req_q, sdr_req_n;

  logic [NP-1:0]         edge_c;
  logic                  any_low_c;
  logic [1:0]            gsel_c;
  logic [1:0]            cand_c;

  assign edge_c = req & ~req_d_q;

  // Grant select: port 0 unless starved-out, else round-robin over 1..3.
  // The cyclic search runs backwards so the first hit after rr_last wins.
  always_comb begin
    gsel_c    = 2'd0;
    cand_c    = 2'd0;
    any_low_c = |pend_q[3:1];
    if (!(pend_q[0] && ((starve_q < SW'(STARVE_LIMIT)) || !any_low_c))) begin
      for (int k = 3; k >= 1; k--) begin
        cand_c = 2'(((int'(rr_last_q) + k - 1) % 3) + 1);
        if (pend_q[cand_c]) begin
          gsel_c = cand_c;
        end
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n    = state_q;
    pend_n     = pend_q;
    paddr_n    = paddr_q;
    starve_n   = starve_q;
    rr_last_n  = rr_last_q;
    sel_n      = sel_q;
    timer_n    = timer_q;
    data_n     = data_q;
    busy_n     = busy_q;
    sdr_addr_n = sdr_addr_q;
    rdy_n      = '0;
    ovf_n      = '0;
    err_n      = 1'b0;
    sdr_req_n  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          sdr_addr_n     = BASE_ADDR | {4'b0, paddr_q[gsel_c]};
          sdr_req_n      = 1'b1;
          pend_n[gsel_c] = 1'b0;
          timer_n        = '0;
          busy_n         = 1'b1;
          sel_n          = gsel_c;
          state_n        = ST_WAIT;
          if (gsel_c == 2'd0) begin
            if (any_low_c) begin
              if (starve_q < SW'(STARVE_LIMIT)) begin
                starve_n = starve_q + 1'b1;
              end
            end else begin
              starve_n = '0;
            end
          end else begin
            starve_n  = '0;
            rr_last_n = gsel_c;
          end
        end
      end
      ST_WAIT: begin
        // sdr_rdy takes precedence over a coincident timeout.
        if (sdr_rdy) begin
          data_n       = sdr_data;
          rdy_n[sel_q] = 1'b1;
          busy_n       = 1'b0;
          state_n      = ST_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          data_n       = '0;
          rdy_n[sel_q] = 1'b1;
          err_n        = 1'b1;
          busy_n       = 1'b0;
          state_n      = ST_IDLE;
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Capture last so a same-cycle edge on the granted port stays pending.
    for (int i = 0; i < NP; i++) begin
      if (edge_c[i]) begin
        pend_n[i]  = 1'b1;
        paddr_n[i] = addr[AW*i +: AW];
        ovf_n[i]   = pend_q[i];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      req_d_q    <= '0;
      paddr_q    <= '0;
      starve_q   <= '0;
      rr_last_q  <= 2'd3;
      sel_q      <= 2'd0;
      timer_q    <= '0;
      data_q     <= '0;
      rdy_q      <= '0;
      ovf_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      sdr_addr_q <= '0;
      sdr_req_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      pend_q     <= pend_n;
      req_d_q    <= req;
      paddr_q    <= paddr_n;
      starve_q   <= starve_n;
      rr_last_q  <= rr_last_n;
      sel_q      <= sel_n;
      timer_q    <= timer_n;
      data_q     <= data_n;
      rdy_q      <= rdy_n;
      ovf_q      <= ovf_n;
      err_q      <= err_n;
      busy_q     <= busy_n;
      sdr_addr_q <= sdr_addr_n;
      sdr_req_q  <= sdr_req_n;
    end
  end

  assign data     = data_q;
  assign rdy      = rdy_q;
  assign err      = err_q;
  assign ovf      = ovf_q;
  assign busy     = busy_q;
  assign sdr_addr = sdr_addr_q;
  assign sdr_req  = sdr_req_q;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Scoreboard bench for tile_rom_arbiter: stimulus pushes expected issues,
// completions and overflow pulses; a monitor pops and compares them.
module tb_tile_rom_arbiter;

  typedef struct {
    logic [24:0] addr;
    int          cyc;
  } iss_t;

  typedef struct {
    logic [3:0]  rdy;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } cmp_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [83:0] addr;
  logic [31:0] data;
  logic [3:0]  rdy;
  logic        err;
  logic [3:0]  ovf;
  logic        busy;
  logic [24:0] sdr_addr;
  logic        sdr_req;
  logic [31:0] sdr_data;
  logic        sdr_rdy;

  iss_t        iss_q[$];
  cmp_t        cmp_q[$];
  logic [3:0]  ovf_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tmo_cnt = 0;
  int rst_chk_req = 0;
  int rst_chk_done = 0;
  int late_cnt = 0;
  int late_done = 0;
  int sdr_lat = 1;
  logic sdr_mute = 1'b0;
  logic tb_done = 1'b0;

  tile_rom_arbiter #(
    .BASE_ADDR    (25'h1000000),
    .STARVE_LIMIT (4),
    .TIMEOUT      (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .addr     (addr),
    .data     (data),
    .rdy      (rdy),
    .err      (err),
    .ovf      (ovf),
    .busy     (busy),
    .sdr_addr (sdr_addr),
    .sdr_req  (sdr_req),
    .sdr_data (sdr_data),
    .sdr_rdy  (sdr_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] sdr_word(input logic [24:0] a);
    if (a == 25'h1000ABC) return 32'hDEADBEEF;
    return {7'h0, a} ^ 32'hC0DE0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  task automatic exp_iss(input logic [24:0] a, input int c);
    iss_t e;
    e.addr = a;
    e.cyc  = c;
    iss_q.push_back(e);
  endtask

  task automatic exp_cmp(input logic [3:0] r, input logic [31:0] d, input logic e_err, input int c);
    cmp_t e;
    e.rdy  = r;
    e.data = d;
    e.err  = e_err;
    e.cyc  = c;
    cmp_q.push_back(e);
  endtask

  task automatic pulse(input int p, input logic [20:0] a);
    addr[21*p +: 21] = a;
    req[p] = 1'b1;
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic wait_sdr_req();
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!sdr_req && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!sdr_req) tmo_cnt++;
  endtask

  task automatic wait_rdy();
    int k;
    k = 0;
    @(posedge clk); #1;
    while (rdy == 4'b0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (rdy == 4'b0) tmo_cnt++;
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    while ((busy || iss_q.size() != 0 || cmp_q.size() != 0) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) tmo_cnt++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // SDRAM model: answers sdr_lat cycles after an issue unless muted;
  // can also inject a stray sdr_rdy pulse on request.
  initial begin : sdram_model
    int          cnt;
    logic [24:0] a;
    cnt = 0;
    a = '0;
    sdr_rdy = 1'b0;
    sdr_data = '0;
    forever begin
      @(negedge clk);
      sdr_rdy = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sdr_rdy  = 1'b1;
          sdr_data = sdr_word(a);
        end
      end
      if (late_cnt != late_done) begin
        late_done = late_cnt;
        sdr_rdy   = 1'b1;
        sdr_data  = 32'hBAD0BAD0;
      end
      if (sdr_req && !sdr_mute && reset_n) begin
        a   = sdr_addr;
        cnt = sdr_lat;
      end
    end
  end

  // Monitor: compares every DUT output event against the scoreboard.
  initial begin : monitor
    iss_t        ie;
    cmp_t        ce;
    logic [3:0]  oe;
    logic [31:0] hold;
    hold = '0;
    forever begin
      @(negedge clk);
      if (rst_chk_req != rst_chk_done) begin
        rst_chk_done = rst_chk_req;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_rdy", 64'(rdy), 64'(0));
        check("reset_sdr_req", 64'(sdr_req), 64'(0));
        check("reset_data", 64'(data), 64'(0));
        check("reset_err_ovf_addr", 64'({err, ovf, sdr_addr}), 64'(0));
      end
      if (!reset_n) begin
        hold = '0;
      end else begin
        if (sdr_req) begin
          if (iss_q.size() == 0) begin
            flag("issue_unexpected");
          end else begin
            ie = iss_q.pop_front();
            check("issue_addr", 64'(sdr_addr), 64'(ie.addr));
            check("issue_busy", 64'(busy), 64'(1));
            if (ie.cyc >= 0) check("issue_cycle", 64'(cyc), 64'(ie.cyc));
          end
        end
        if (rdy != 4'b0) begin
          if (cmp_q.size() == 0) begin
            flag("cmpl_unexpected");
          end else begin
            ce = cmp_q.pop_front();
            check("cmpl_rdy", 64'(rdy), 64'(ce.rdy));
            check("cmpl_data", 64'(data), 64'(ce.data));
            check("cmpl_err", 64'(err), 64'(ce.err));
            check("cmpl_busy", 64'(busy), 64'(0));
            if (ce.cyc >= 0) check("cmpl_cycle", 64'(cyc), 64'(ce.cyc));
            hold = ce.data;
          end
        end else begin
          check("hold_data_err", 64'({err, data}), 64'({1'b0, hold}));
        end
        if (ovf != 4'b0) begin
          if (ovf_q.size() == 0) begin
            flag("ovf_unexpected");
          end else begin
            oe = ovf_q.pop_front();
            check("ovf_bits", 64'(ovf), 64'(oe));
          end
        end
      end
      if (tb_done) begin
        check("issue_left", 64'(iss_q.size()), 64'(0));
        check("cmpl_left", 64'(cmp_q.size()), 64'(0));
        check("ovf_left", 64'(ovf_q.size()), 64'(0));
        check("wait_timeouts", 64'(tmo_cnt), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  // Stimulus.
  initial begin : stimulus
    int n;
    req = '0;
    addr = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    rst_chk_req++;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin: ports 1,2,3 together, SDRAM answers in 2 cycles.
    sdr_lat = 2;
    n = cyc;
    exp_iss(25'h1000011, n + 2);
    exp_cmp(4'b0010, sdr_word(25'h1000011), 1'b0, n + 5);
    exp_iss(25'h1000022, n + 6);
    exp_cmp(4'b0100, sdr_word(25'h1000022), 1'b0, n + 9);
    exp_iss(25'h1000033, n + 10);
    exp_cmp(4'b1000, sdr_word(25'h1000033), 1'b0, n + 13);
    addr[21 +: 21] = 21'h11;
    addr[42 +: 21] = 21'h22;
    addr[63 +: 21] = 21'h33;
    req = 4'b1110;
    @(posedge clk); #1;
    req = '0;
    wait_quiet();

    // Single read, minimum latency.
    sdr_lat = 1;
    n = cyc;
    exp_iss(25'h1000ABC, n + 2);
    exp_cmp(4'b0100, 32'hDEADBEEF, 1'b0, n + 4);
    pulse(2, 21'h00ABC);
    wait_quiet();

    // Starvation: port 0 re-requests while in flight, port 3 waits.
    n = cyc;
    exp_iss(25'h1000100, n + 2);
    exp_cmp(4'b0001, sdr_word(25'h1000100), 1'b0, n + 4);
    for (int k = 1; k <= 3; k++) begin
      exp_iss(25'h1000100 + 25'(k), -1);
      exp_cmp(4'b0001, sdr_word(25'h1000100 + 25'(k)), 1'b0, -1);
    end
    exp_iss(25'h1000333, -1);
    exp_cmp(4'b1000, sdr_word(25'h1000333), 1'b0, -1);
    exp_iss(25'h1000104, -1);
    exp_cmp(4'b0001, sdr_word(25'h1000104), 1'b0, -1);
    addr[0 +: 21]  = 21'h100;
    addr[63 +: 21] = 21'h333;
    req = 4'b1001;
    @(posedge clk); #1;
    req = '0;
    for (int k = 1; k <= 4; k++) begin
      wait_sdr_req();
      pulse(0, 21'h100 + 21'(k));
    end
    wait_quiet();

    // Overwrite: port 1 re-requests while still pending behind port 0.
    sdr_lat = 2;
    exp_iss(25'h1000200, -1);
    exp_cmp(4'b0001, sdr_word(25'h1000200), 1'b0, -1);
    ovf_q.push_back(4'b0010);
    exp_iss(25'h1000009, -1);
    exp_cmp(4'b0010, sdr_word(25'h1000009), 1'b0, -1);
    pulse(0, 21'h200);
    wait_sdr_req();
    pulse(1, 21'h5);
    @(posedge clk); #1;
    pulse(1, 21'h9);
    wait_quiet();

    // Timeout, stray sdr_rdy in IDLE, then the queued port 1 read.
    sdr_lat = 1;
    sdr_mute = 1'b1;
    n = cyc;
    exp_iss(25'h1000777, n + 2);
    exp_cmp(4'b0100, 32'h0, 1'b1, n + 10);
    exp_iss(25'h1000055, -1);
    exp_cmp(4'b0010, sdr_word(25'h1000055), 1'b0, -1);
    pulse(2, 21'h777);
    wait_sdr_req();
    pulse(1, 21'h55);
    wait_rdy();
    late_cnt++;
    sdr_mute = 1'b0;
    wait_quiet();

    // Asynchronous reset mid-read with another port pending.
    sdr_mute = 1'b1;
    n = cyc;
    exp_iss(25'h100003A, n + 2);
    pulse(3, 21'h3A);
    wait_sdr_req();
    pulse(1, 21'h44);
    @(posedge clk);
    #3 reset_n = 1'b0;
    rst_chk_req++;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    sdr_mute = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Fresh read after reset issues alone.
    n = cyc;
    exp_iss(25'h100002B, n + 2);
    exp_cmp(4'b0100, sdr_word(25'h100002B), 1'b0, n + 4);
    pulse(2, 21'h2B);
    wait_quiet();

    tb_done = 1'b1;
  end

endmodule
